// File: rtl/mmd_div_ctrl.sv
// Multi-modulus divider control. It divides the fast clock by a clamped
// N + div_ctrl modulus and asks the sigma-delta modulator for its next
// sample once per divided period.
module mmd_div_ctrl #(
  parameter int W       = 6,
  parameter int MIN_DIV = 8,
  parameter int MAX_DIV = 63,
  parameter int PCW     = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic [W-1:0]   N,
  input  logic [W-1:0]   div_ctrl,
  output logic           div_out,
  output logic           sdm_req,
  output logic           sat,
  output logic [W:0]     ratio,
  output logic [PCW-1:0] pcnt
);

  localparam logic signed [W+1:0] MIN_S = (W+2)'(MIN_DIV);
  localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX_DIV);
  localparam logic [W:0]          MIN_R = (W+1)'(MIN_DIV);
  localparam logic [W:0]          MAX_R = (W+1)'(MAX_DIV);
  localparam logic [W:0]          ONE   = (W+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  logic [W:0]      r_cnt;
  logic [W:0]      r_ratio;
  logic            r_div;
  logic            r_req;
  logic            r_sat;
  logic [PCW-1:0]  r_pcnt;

  logic signed [W+1:0] w_sum;
  logic [W:0]          w_r;
  logic                w_clamp;
  logic [W:0]          w_cnt_dec;

  // Clamped modulus from the unsigned ratio plus the signed sdm offset.
  always_comb begin
    w_sum   = $signed({2'b00, N}) + $signed({{2{div_ctrl[W-1]}}, div_ctrl});
    w_r     = w_sum[W:0];
    w_clamp = 1'b0;
    if (w_sum < MIN_S) begin
      w_r     = MIN_R;
      w_clamp = 1'b1;
    end else if (w_sum > MAX_S) begin
      w_r     = MAX_R;
      w_clamp = 1'b1;
    end
    w_cnt_dec = r_cnt - ONE;
  end

  // Divider FSM: cnt runs ratio..1; a new modulus is latched on the cnt==1 edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ratio <= '0;
      r_div   <= 1'b0;
      r_req   <= 1'b0;
      r_sat   <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_req <= 1'b0;
      r_sat <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_div <= 1'b0;
          if (en) begin
            r_state <= RUN;
            r_ratio <= w_r;
            r_cnt   <= w_r;
            r_req   <= 1'b1;
            r_sat   <= w_clamp;
            r_div   <= 1'b1;   // cnt==ratio is always above ratio/2
          end
        end
        default: begin
          if (r_cnt == ONE) begin
            r_pcnt <= r_pcnt + 1'b1;
            if (en) begin
              r_ratio <= w_r;
              r_cnt   <= w_r;
              r_req   <= 1'b1;
              r_sat   <= w_clamp;
              r_div   <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_div   <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_dec;
            r_div <= (w_cnt_dec > (r_ratio >> 1));
          end
        end
      endcase
    end
  end

  assign div_out = r_div;
  assign sdm_req = r_req;
  assign sat     = r_sat;
  assign ratio   = r_ratio;
  assign pcnt    = r_pcnt;

endmodule

// File: tb/tb_mmd_div_ctrl.sv
// Bench for mmd_div_ctrl: a period-position model is compared every cycle,
// plus literal checks on known ratio/length cases.
module tb_mmd_div_ctrl;
  localparam int W   = 6;
  localparam int PCW = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   N = '0;
  logic [W-1:0]   div_ctrl = '0;
  logic           div_out, sdm_req, sat;
  logic [W:0]     ratio;
  logic [PCW-1:0] pcnt;

  mmd_div_ctrl #(.W(W), .MIN_DIV(8), .MAX_DIV(63), .PCW(PCW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .N(N), .div_ctrl(div_ctrl),
    .div_out(div_out), .sdm_req(sdm_req), .sat(sat), .ratio(ratio), .pcnt(pcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: position k within the current period of length R.
  bit m_run;
  int m_k, m_R, m_pc;
  bit m_clamp;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 0; m_k = 0; m_R = 0; m_pc = 0; m_clamp = 0;
    end else if (!m_run || m_k == m_R - 1) begin
      if (m_run) m_pc = (m_pc + 1) % (1 << PCW);
      if (en) begin
        int s;
        s = int'(N) + int'($signed(div_ctrl));
        m_clamp = (s < 8) || (s > 63);
        m_R = (s < 8) ? 8 : (s > 63) ? 63 : s;
        m_k = 0;
        m_run = 1;
      end else begin
        m_run = 0;
        m_k = 0;
      end
    end else begin
      m_k++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("div_out", int'(div_out), (m_run && m_k < (m_R + 1) / 2) ? 1 : 0);
      chk("sdm_req", int'(sdm_req), (m_run && m_k == 0) ? 1 : 0);
      chk("sat",     int'(sat),     (m_run && m_k == 0 && m_clamp) ? 1 : 0);
      chk("ratio",   int'(ratio),   m_R);
      chk("pcnt",    int'(pcnt),    m_pc);
    end
  end

  // Counts negedges until one shows sdm_req; -1 if the budget expires.
  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sdm_req && cyc < 200);
    if (!sdm_req) begin
      cyc = -1;
      chk("req_timeout", 0, 1);
    end
  endtask

  task automatic set_in(input int n, input int d);
    N = W'(n);
    div_ctrl = W'(d);
  endtask

  // Two requests so the period under test was latched with the new inputs.
  task automatic pin_ratio(input string nm, input int n, input int d,
                           input int exp_r, input int exp_sat);
    int c;
    set_in(n, d);
    wait_req(c);
    wait_req(c);
    chk({nm, "_ratio"}, int'(ratio), exp_r);
    chk({nm, "_sat"}, int'(sat), exp_sat);
  endtask

  initial begin
    int c, tot, hi, p0;
    // Reset state
    #12;
    chk("rst_div_out", int'(div_out), 0);
    chk("rst_sdm_req", int'(sdm_req), 0);
    chk("rst_ratio", int'(ratio), 0);
    chk("rst_pcnt", int'(pcnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    chk_en = 1'b1;

    // N=31, div_ctrl=0: period 31, 16 high
    set_in(31, 0);
    en = 1'b1;
    wait_req(c);
    hi = 0;
    c = 0;
    do begin
      if (div_out) hi++;
      @(negedge clk);
      c++;
    end while (!sdm_req && c < 200);
    chk("n31_period", c, 31);
    chk("n31_high", hi, 16);
    chk("n31_ratio", int'(ratio), 31);

    // Clamp cases
    pin_ratio("n3m2", 3, -2, 8, 1);
    pin_ratio("n63p31", 63, 31, 63, 1);
    pin_ratio("n40m32", 40, -32, 8, 0);
    pin_ratio("n0", 0, 0, 8, 1);

    // Alternating +1/-1, 1000 periods averaging 31
    set_in(31, 1);
    wait_req(c);
    wait_req(c);
    tot = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      div_ctrl = (div_ctrl == W'(1)) ? W'(-1) : W'(1);
      wait_req(c);
      tot += c + 1;
    end
    chk("alt_total", tot, 31000);

    // en dropped 5 cycles into a 31-cycle period
    set_in(31, 0);
    wait_req(c);
    wait_req(c);
    p0 = m_pc;
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (40) @(negedge clk);
    chk("drop_pcnt", int'(pcnt), (p0 + 1) % (1 << PCW));
    chk("drop_div_out", int'(div_out), 0);

    // Re-enable from IDLE
    set_in(20, 3);
    en = 1'b1;
    @(negedge clk);
    chk("reen_req", int'(sdm_req), 1);
    chk("reen_ratio", int'(ratio), 23);

    // Randomized inputs
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) N = W'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) div_ctrl = W'($urandom_range(0, 63));
      if ($urandom_range(0, 49) == 0) en = ~en;
    end

    // Asynchronous reset between edges mid-period
    set_in(31, 0);
    en = 1'b1;
    wait_req(c);
    repeat (7) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_div_out", int'(div_out), 0);
    chk("arst_ratio", int'(ratio), 0);
    chk("arst_pcnt", int'(pcnt), 0);
    chk("arst_sat", int'(sat), 0);
    @(negedge clk);
    set_in(8, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_req", int'(sdm_req), 1);
    chk("rel_pcnt", int'(pcnt), 0);

    // 17 periods of 8 on a 4-bit counter: reads 1 after the wrap
    for (int i = 0; i < 17; i++) wait_req(c);
    chk("wrap_pcnt", int'(pcnt), 1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
